// File: rtl/input_arb.sv
// input_arb: shares one AXI read port (AR/R) among Np input-cache requesters.
// One burst is in flight at a time. The arbiter grants a requester, issues its
// address, and steers the returned beats to that requester only.
// Build option: define INPUT_ARB_RR_EN for round-robin selection. Without it,
// fixed priority is used (the highest set index wins).
module input_arb #(
  parameter int unsigned Np = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [Np-1:0]       rreq,
  output logic [Np-1:0]       rgnt,
  input  logic [Np-1:0][31:0] radr,
  input  logic [Np-1:0][7:0]  rlen,
  input  logic [31:0]         baseadr,
  output logic [63:0]         rdo,
  output logic [Np-1:0]       rvo,
  output logic [Np-1:0]       rlo,
  output logic                err_len,
  output logic [39:0]         araddr,
  output logic [7:0]          arlen,
  output logic                arvalid,
  input  logic                arready,
  input  logic [63:0]         rd_data,
  input  logic                rvalid,
  input  logic                rlast,
  output logic                rready
);

  localparam int unsigned ChW = (Np > 1) ? $clog2(Np) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e         state_q, state_d;
  logic [ChW-1:0] ch_q, ch_d;
  logic [ChW-1:0] sel;
  logic           any_req;
  logic [31:0]    addr_q, addr_d;
  logic [7:0]     len_q, len_d;
  logic [8:0]     cnt_q, cnt_d;
  logic           err_q, err_d;

  assign any_req = |rreq;

`ifdef INPUT_ARB_RR_EN
  logic [ChW-1:0] ptr_q, ptr_d;

  // Round-robin pick: first requester strictly after the last grant, wrapping.
  always_comb begin
    int unsigned idx;
    logic        found;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= Np; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= Np) idx = idx - Np;
      if (!found && rreq[idx[ChW-1:0]]) begin
        sel   = idx[ChW-1:0];
        found = 1'b1;
      end
    end
  end

  // Pointer follows the channel that was just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StIdle && any_req) ptr_d = sel;
  end

  // Pointer register; reset to Np-1 so channel 0 is served first.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= ChW'(Np - 1);
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority pick: ascending scan, so the highest set index ends up winning.
  always_comb begin
    sel = '0;
    for (int unsigned k = 0; k < Np; k++) begin
      if (rreq[k[ChW-1:0]]) sel = k[ChW-1:0];
    end
  end
`endif

  // Read data is a broadcast passthrough; only rvo qualifies it per channel.
  assign rdo     = rd_data;
  assign araddr  = {8'h00, addr_q};
  assign arlen   = len_q;
  assign err_len = err_q;

  // Next-state and output decode for the grant/address/data sequence.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rgnt    = '0;
    rvo     = '0;
    rlo     = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (any_req) begin
          ch_d      = sel;
          // Address and length are captured here so AR stays stable while stalled.
          addr_d    = baseadr + (radr[sel] & 32'hFFFF_FFF8);
          len_d     = rlen[sel];
          rgnt[sel] = 1'b1;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        arvalid = 1'b1;
        if (arready) state_d = StData;
      end
      StData: begin
        rready = 1'b1;
        if (rvalid) begin
          rvo[ch_q] = 1'b1;
          if (cnt_q != 9'h1FF) cnt_d = cnt_q + 9'd1;
          if (rlast) begin
            rlo[ch_q] = 1'b1;
            state_d   = StIdle;
            // cnt_q holds beats before this one, so a correct burst ends at rlen.
            if (cnt_q != {1'b0, len_q}) err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset drops any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ch_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
